// File: rtl/sata_crc_inserter.sv
// SATA frame CRC inserter: forwards data dwords with one clock of latency and
// appends the running CRC-32 (poly 0x04C11DB7, MSB first, no reflection) after each frame.
module sata_crc_inserter #(
  parameter logic [31:0] INIT = 32'h52325032
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_dat,
  input  logic        i_val,
  input  logic        i_eop,
  output logic        i_rdy,
  output logic [31:0] o_dat,
  output logic        o_val,
  output logic        o_eop,
  input  logic        o_rdy,
  output logic        dbg_crc_state
);

  // Handshake: a dword moves across a port on any rising edge where that
  // port's valid and ready are both 1. Valid never depends on ready; once
  // o_val is raised, o_dat/o_eop stay frozen until the transfer happens.

  localparam logic [31:0] POLY = 32'h04C11DB7;

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_CRC  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] crc;
  logic [31:0] crc_n;
  logic [31:0] o_dat_n;
  logic        o_val_n;
  logic        o_eop_n;
  logic        slot_free;
  logic        in_xfer;

  // One whole-dword step: ((crc ^ d) * x^32) mod P, shifting MSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] v;
    v = c ^ d;
    for (int b = 0; b < 32; b++) begin
      if (v[31]) v = (v << 1) ^ POLY;
      else       v = v << 1;
    end
    return v;
  endfunction

  always_comb begin
    slot_free = !o_val || o_rdy;
    i_rdy     = (state == ST_DATA) && slot_free;
    in_xfer   = i_val && i_rdy;
  end

  always_comb begin
    state_n = state;
    crc_n   = crc;
    o_dat_n = o_dat;
    o_val_n = o_val;
    o_eop_n = o_eop;
    case (state)
      ST_DATA: begin
        if (in_xfer) begin
          o_dat_n = i_dat;
          o_val_n = 1'b1;
          o_eop_n = 1'b0;
          crc_n   = crc_step(crc, i_dat);
          if (i_eop) state_n = ST_CRC;
        end else if (slot_free) begin
          o_val_n = 1'b0;
          o_eop_n = 1'b0;
        end
      end
      ST_CRC: begin
        // The CRC dword takes the slot as soon as the last data dword leaves it.
        if (slot_free) begin
          o_dat_n = crc;
          o_val_n = 1'b1;
          o_eop_n = 1'b1;
          crc_n   = INIT;
          state_n = ST_DATA;
        end
      end
      default: state_n = ST_DATA;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_DATA;
      crc   <= INIT;
      o_dat <= 32'h0;
      o_val <= 1'b0;
      o_eop <= 1'b0;
    end else begin
      state <= state_n;
      crc   <= crc_n;
      o_dat <= o_dat_n;
      o_val <= o_val_n;
      o_eop <= o_eop_n;
    end
  end

  assign dbg_crc_state = (state == ST_CRC);

endmodule

// File: tb/tb_sata_crc_inserter.sv
// Bench for sata_crc_inserter: directed frames with literal expectations, then
// random frames with random gaps/backpressure checked against a queue model.
module tb_sata_crc_inserter;

  localparam logic [31:0] SEED = 32'h52325032;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT with default seed ----------------
  logic [31:0] i_dat = '0;
  logic        i_val = 1'b0;
  logic        i_eop = 1'b0;
  logic        i_rdy;
  logic [31:0] o_dat;
  logic        o_val;
  logic        o_eop;
  logic        o_rdy = 1'b1;
  logic        dbg;

  sata_crc_inserter dut (
    .clk(clk), .reset(rst),
    .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
    .o_dat(o_dat), .o_val(o_val), .o_eop(o_eop), .o_rdy(o_rdy),
    .dbg_crc_state(dbg)
  );

  // ---------------- DUT with zero seed ----------------
  logic [31:0] i_dat0 = '0;
  logic        i_val0 = 1'b0;
  logic        i_eop0 = 1'b0;
  logic        i_rdy0;
  logic [31:0] o_dat0;
  logic        o_val0;
  logic        o_eop0;
  logic        o_rdy0 = 1'b1;
  logic        dbg0;

  sata_crc_inserter #(.INIT(32'h0)) dut0 (
    .clk(clk), .reset(rst),
    .i_dat(i_dat0), .i_val(i_val0), .i_eop(i_eop0), .i_rdy(i_rdy0),
    .o_dat(o_dat0), .o_val(o_val0), .o_eop(o_eop0), .o_rdy(o_rdy0),
    .dbg_crc_state(dbg0)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference CRC step as polynomial long division of (crc ^ d) * x^32 by P.
  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [31:0] d);
    logic [63:0] v;
    v = {c ^ d, 32'h0};
    for (int i = 63; i >= 32; i--)
      if (v[i]) v = v ^ ({32'h1, POLY} << (i - 32));
    return v[31:0];
  endfunction

  // ---------------- scoreboard (default-seed DUT) ----------------
  logic [32:0] exp_q[$];
  logic [32:0] log_q[$];
  int          log_cyc[$];
  logic [31:0] mcrc = SEED;
  int          eop_seen = 0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_out;

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_o_val", {63'h0, o_val}, 64'h0);
      chk("reset_o_eop", {63'h0, o_eop}, 64'h0);
      chk("reset_o_dat", {32'h0, o_dat}, 64'h0);
      exp_q.delete();
      mcrc = SEED;
      prev_stall = 1'b0;
    end else begin
      // Anything accepted but not yet delivered must be sitting in the slot.
      chk("o_val_vs_model", {63'h0, o_val}, {63'h0, exp_q.size() != 0});
      chk("i_rdy_vs_model", {63'h0, i_rdy},
          {63'h0, (!o_val || o_rdy) && (exp_q.size() <= (o_val ? 1 : 0))});
      if (prev_stall)
        chk("hold_under_stall", {31'h0, o_val, o_eop, o_dat}, {31'h0, 1'b1, prev_out});
      if (o_val && o_rdy) begin
        log_q.push_back({o_eop, o_dat});
        log_cyc.push_back(cyc);
        if (o_eop) eop_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got 0x%0h eop=%0b, expected no output", o_dat, o_eop);
        end else begin
          chk("out_stream", {31'h0, o_eop, o_dat}, {31'h0, exp_q.pop_front()});
        end
      end
      if (i_val && i_rdy) begin
        exp_q.push_back({1'b0, i_dat});
        mcrc = crc_ref(mcrc, i_dat);
        if (i_eop) begin
          exp_q.push_back({1'b1, mcrc});
          mcrc = SEED;
        end
      end
      prev_stall = o_val && !o_rdy;
      prev_out   = {o_eop, o_dat};
    end
  end

  // Output log of the zero-seed DUT.
  logic [32:0] log0_q[$];
  int          log0_cyc[$];
  always @(negedge clk)
    if (!rst && o_val0 && o_rdy0) begin
      log0_q.push_back({o_eop0, o_dat0});
      log0_cyc.push_back(cyc);
    end

  // Random backpressure when enabled.
  logic rand_ordy = 1'b0;
  always @(posedge clk)
    if (rand_ordy) begin
      #1;
      o_rdy = ($urandom_range(0, 3) != 0);
    end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_dword(input logic [31:0] d, input logic eop, input int gap_max);
    int gap;
    logic acc;
    int tmo;
    gap = (gap_max == 0) ? 0 : $urandom_range(0, gap_max);
    repeat (gap) begin
      i_val = 1'b0;
      i_dat = $urandom;
      i_eop = $urandom_range(0, 1);
      tick();
    end
    i_val = 1'b1;
    i_dat = d;
    i_eop = eop;
    tmo = 0;
    acc = 1'b0;
    while (!acc && tmo < 2000) begin
      @(negedge clk);
      acc = i_rdy;
      tick();
      tmo++;
    end
    if (!acc) chk("send_timeout", 64'h0, 64'h1);
    i_val = 1'b0;
    i_eop = 1'b0;
  endtask

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int tmo;
    int eop_base;
    logic acc;

    // Model pinned to hand-computed values.
    chk("model_seed_self", {32'h0, crc_ref(SEED, 32'h52325032)}, 64'h0);
    chk("model_seed_plus1", {32'h0, crc_ref(SEED, 32'h52325033)}, {32'h0, POLY});
    chk("model_zero_one", {32'h0, crc_ref(32'h0, 32'h1)}, {32'h0, POLY});

    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("post_reset_i_rdy", {63'h0, i_rdy}, 64'h1);
    chk("post_reset_o_val", {63'h0, o_val}, 64'h0);

    // Single dword equal to the seed: CRC collapses to zero.
    clear_log();
    send_dword(32'h52325032, 1'b1, 0);
    repeat (3) tick();
    chk("f27_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("f27_data", {31'h0, log_q[0]}, {31'h0, 1'b0, 32'h52325032});
      chk("f27_crc", {31'h0, log_q[1]}, {31'h0, 1'b1, 32'h0});
      chk("f27_consecutive", log_cyc[1] - log_cyc[0], 1);
    end

    // Seed+1 yields the polynomial itself; i_rdy low in the CRC cycle only.
    clear_log();
    send_dword(32'h52325033, 1'b1, 0);
    @(negedge clk);
    chk("f28_i_rdy_crc_state", {63'h0, i_rdy}, 64'h0);
    tick();
    @(negedge clk);
    chk("f28_i_rdy_after", {63'h0, i_rdy}, 64'h1);
    repeat (2) tick();
    chk("f28_count", log_q.size(), 2);
    if (log_q.size() == 2)
      chk("f28_crc", {31'h0, log_q[1]}, {31'h0, 1'b1, POLY});

    // Backpressure for 5 cycles with the next frame waiting at the input.
    clear_log();
    o_rdy = 1'b0;
    send_dword(32'h52325032, 1'b1, 0);
    i_val = 1'b1;
    i_dat = 32'h52325033;
    i_eop = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_o_val", {63'h0, o_val}, 64'h1);
      chk("bp_o_dat", {32'h0, o_dat}, 64'h52325032);
      chk("bp_i_rdy", {63'h0, i_rdy}, 64'h0);
      tick();
    end
    o_rdy = 1'b1;
    send_dword(32'h52325033, 1'b1, 0);
    repeat (3) tick();
    chk("bp_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("bp_out0", {31'h0, log_q[0]}, {31'h0, 1'b0, 32'h52325032});
      chk("bp_out1", {31'h0, log_q[1]}, {31'h0, 1'b1, 32'h0});
      chk("bp_out3", {31'h0, log_q[3]}, {31'h0, 1'b1, POLY});
    end

    // Sustained throughput: 4-dword then 3-dword frame, i_val held high.
    clear_log();
    for (int k = 0; k < 4; k++) send_dword($urandom, k == 3, 0);
    for (int k = 0; k < 3; k++) send_dword($urandom, k == 2, 0);
    repeat (3) tick();
    chk("tput_count", log_q.size(), 9);
    if (log_q.size() == 9) begin
      chk("tput_span", log_cyc[8] - log_cyc[0], 8);
      chk("tput_eop_pos", {62'h0, log_q[4][32], log_q[8][32]}, 64'h3);
    end

    // Reset in the middle of a 4-dword frame.
    send_dword($urandom, 1'b0, 0);
    send_dword($urandom, 1'b0, 0);
    rst = 1'b1;
    #1;
    chk("midreset_o_val", {63'h0, o_val}, 64'h0);
    tick();
    rst = 1'b0;
    clear_log();
    send_dword(32'h52325032, 1'b1, 0);
    repeat (3) tick();
    chk("midreset_count", log_q.size(), 2);
    if (log_q.size() == 2)
      chk("midreset_crc", {31'h0, log_q[1]}, {31'h0, 1'b1, 32'h0});

    // Zero-seed DUT: two back-to-back single-dword frames.
    i_val0 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_dat0 = k;
      i_eop0 = 1'b1;
      acc = 1'b0;
      tmo = 0;
      while (!acc && tmo < 20) begin
        @(negedge clk);
        acc = i_rdy0;
        tick();
        tmo++;
      end
      if (!acc) chk("z_send_timeout", 64'h0, 64'h1);
    end
    i_val0 = 1'b0;
    repeat (4) tick();
    chk("z_count", log0_q.size(), 4);
    if (log0_q.size() == 4) begin
      chk("z_out0", {31'h0, log0_q[0]}, {31'h0, 1'b0, 32'h0});
      chk("z_out1", {31'h0, log0_q[1]}, {31'h0, 1'b1, 32'h0});
      chk("z_out2", {31'h0, log0_q[2]}, {31'h0, 1'b0, 32'h1});
      chk("z_out3", {31'h0, log0_q[3]}, {31'h0, 1'b1, POLY});
      chk("z_span", log0_cyc[3] - log0_cyc[0], 3);
    end

    // Random frames with random input gaps and output backpressure.
    eop_base = eop_seen;
    rand_ordy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      n = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(1, 64);
      for (int k = 0; k < n; k++) send_dword($urandom, k == n - 1, 2);
    end
    rand_ordy = 1'b0;
    tick();
    o_rdy = 1'b1;
    tmo = 0;
    while ((exp_q.size() != 0 || o_val) && tmo < 200) begin
      tick();
      tmo++;
    end
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_eop_count", eop_seen - eop_base, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
